// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types and constants for the BCD display driver
package bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam int         BCD_MAX   = 9999;
    localparam int         NIBBLE_W  = 4;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter with valid/ready intake
module bin2bcd_seq
    import bcd_display_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_value,
    output logic                  busy,
    output logic [4*NIBBLE_W-1:0] digits,
    output logic                  range_ovf,
    output logic                  done
);

    // Accumulator sized for the widest input so the shift never loses carries.
    localparam int ACC_N = ((IN_W + 2) / 3 > 4) ? (IN_W + 2) / 3 : 4;
    localparam int ACC_W = ACC_N * NIBBLE_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t            state;
    logic [ACC_W-1:0]  bcd_q;
    logic [ACC_W-1:0]  bcd_adj;
    logic [IN_W-1:0]   bin_q;
    logic [CNT_W-1:0]  cnt;
    logic              range_q;
    logic [ACC_W+IN_W-1:0] shifted;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < ACC_N; i++) begin
            bcd_adj[i*NIBBLE_W +: NIBBLE_W] = add3(bcd_q[i*NIBBLE_W +: NIBBLE_W]);
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt     <= '0;
            range_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_q   <= in_value;
                        bcd_q   <= '0;
                        cnt     <= CNT_W'(IN_W);
                        range_q <= 32'(in_value) > 32'(BCD_MAX);
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {bcd_q, bin_q} <= shifted;
                    cnt            <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = !in_ready;
    assign done      = (state == ST_COMMIT);
    assign digits    = bcd_q[4*NIBBLE_W-1:0];
    assign range_ovf = range_q;

endmodule

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - binary to multiplexed BCD digit driver with blanking
module bcd_display_driver
    import bcd_display_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int LZB      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_value,
    output logic                busy,
    output logic                ovf,
    output logic [3:0]          bcd_out,
    output logic [DIGITS-1:0]   an_n
);

    localparam int PSC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [4*NIBBLE_W-1:0] conv_digits;
    logic                  conv_ovf;
    logic                  conv_done;

    logic [3:0]        dig [DIGITS];
    logic              ovf_q;
    logic [PSC_W-1:0]  psc;
    logic [IDX_W-1:0]  idx;
    logic [DIGITS-1:0] blank;
    logic              zero_above;

    bin2bcd_seq #(.IN_W(IN_W)) u_conv (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .busy      (busy),
        .digits    (conv_digits),
        .range_ovf (conv_ovf),
        .done      (conv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) dig[i] <= '0;
            ovf_q <= 1'b0;
            psc   <= '0;
            idx   <= '0;
        end else begin
            if (conv_done) begin
                for (int i = 0; i < DIGITS; i++) dig[i] <= conv_digits[i*NIBBLE_W +: NIBBLE_W];
                ovf_q <= conv_ovf;
            end
            if (psc == PSC_W'(SCAN_DIV - 1)) begin
                psc <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                psc <= psc + PSC_W'(1);
            end
        end
    end

    // A digit blanks only when it and every more significant digit are zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (dig[i] == 4'd0);
            blank[i]   = ovf_q || ((LZB != 0) && zero_above);
        end
        blank[0] = ovf_q;
    end

    assign ovf     = ovf_q;
    assign bcd_out = blank[idx] ? BCD_BLANK : dig[idx];
    assign an_n    = ~(DIGITS'(1) << idx);

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - scoreboard bench for bcd_display_driver
module tb_bcd_display_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [13:0] in_value = '0;
    logic        rdy0, busy0, ovf0, rdy1, busy1, ovf1;
    logic [3:0]  bcd0, bcd1, an0, an1;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    bcd_display_driver #(.IN_W(14), .DIGITS(4), .SCAN_DIV(SD), .LZB(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_value(in_value),
        .busy(busy0), .ovf(ovf0), .bcd_out(bcd0), .an_n(an0)
    );

    bcd_display_driver #(.IN_W(14), .DIGITS(4), .SCAN_DIV(SD), .LZB(0)) dut_nolzb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_value(in_value),
        .busy(busy1), .ovf(ovf1), .bcd_out(bcd1), .an_n(an1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int v, input bit lzb);
        logic [15:0] r;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (v > 9999)                  r[4*i +: 4] = 4'hF;
            else if (lzb && i > 0 && v < p) r[4*i +: 4] = 4'hF;
            else                           r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int pos_of(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic push(input int v);
        q0.push_back(model(v, 1'b1));
        q1.push_back(model(v, 1'b0));
    endtask

    task automatic scan(input string tag, input int n);
        logic [15:0] s0, s1, e0, e1;
        logic [3:0]  seen0, seen1;
        int p0, p1, bad_an;
        s0 = '0; s1 = '0; seen0 = '0; seen1 = '0; bad_an = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            p0 = pos_of(an0);
            p1 = pos_of(an1);
            if (p0 < 0 || p1 < 0) bad_an++;
            else begin
                s0[4*p0 +: 4] = bcd0; seen0[p0] = 1'b1;
                s1[4*p1 +: 4] = bcd1; seen1[p1] = 1'b1;
            end
        end
        check({tag, " anode one-hot"}, bad_an, 0);
        check({tag, " all anodes seen"}, {seen1, seen0}, 8'hFF);
        if (q0.size() == 0 || q1.size() == 0) begin
            check({tag, " scoreboard empty"}, 1, 0);
        end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check({tag, " digits lzb=1"}, s0, e0);
            check({tag, " digits lzb=0"}, s1, e1);
        end
    endtask

    // Starts on a negedge; returns on the negedge after the accept edge.
    task automatic send(input int v);
        int w;
        in_valid = 1'b1;
        in_value = 14'(v);
        push(v);
        w = 0;
        while (!rdy0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready wait", w < 100, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_conv(input string tag, input int v);
        int n;
        check({tag, " busy"}, busy0, 1);
        n = 0;
        while (!rdy0 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, " ready-low cycles"}, n, 15);
        check({tag, " ovf"}, ovf0, (v > 9999) ? 1 : 0);
    endtask

    int vals[7] = '{1234, 9999, 10000, 7, 0, 1005, 42};
    int t300, t500, w, n8;

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset an_n", an0, 4'b1110);
        check("reset bcd_out", bcd0, 4'h0);
        check("reset in_ready", rdy0, 1);
        check("reset ovf", ovf0, 0);
        check("reset busy", busy0, 0);
        push(0);
        scan("reset", 4 * SD);

        for (int i = 0; i < 7; i++) begin
            send(vals[i]);
            finish_conv($sformatf("val %0d", vals[i]), vals[i]);
            scan($sformatf("val %0d", vals[i]), 4 * SD);
        end

        send(300);
        in_valid = 1'b1;
        in_value = 14'd500;
        push(500);
        w = 0;
        while (!rdy0 && w < 40) begin
            w++;
            @(negedge clk);
        end
        check("hs 300 ready-low cycles", w, 15);
        t300 = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("hs 500 accepted", rdy0, 0);
        scan("hs 300", 13);
        w = 0;
        while (!rdy0 && w < 40) begin
            w++;
            @(negedge clk);
        end
        t500 = cyc;
        check("hs commit spacing", t500 - t300, 16);
        scan("hs 500", 4 * SD);

        check("midrst ready", rdy0, 1);
        in_valid = 1'b1;
        in_value = 14'd8888;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst an_n", an0, 4'b1110);
        check("midrst bcd_out", bcd0, 4'h0);
        check("midrst ready", rdy0, 1);
        n8 = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bcd0 == 4'd8 || bcd1 == 4'd8) n8++;
        end
        check("midrst no 8888", n8, 0);
        push(0);
        scan("midrst", 4 * SD);

        send(12);
        finish_conv("val 12", 12);
        scan("val 12", 4 * SD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
